// File: rtl/vm_coin_acceptor.sv
// Coin acceptor front end: debounces the three slot inputs, keeps the session credit,
// applies purchase deductions and issues one-shot refund records. Slot inputs are clk-synchronous.
module vm_coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_CREDIT      = 200,
  parameter int PRICE_G1        = 5,
  parameter int PRICE_G2        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_p5,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       occupy,
  input  logic       g1_bought,
  input  logic       g2_bought,
  input  logic       ret_coin,
  output logic [7:0] coin_value,
  output logic       coin_accepted,
  output logic       coin_rejected,
  output logic       refund_valid,
  output logic [7:0] refund_amount,
  output logic       credit_err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REFUND = 2'd2
  } state_t;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [7:0]         credit_q, credit_d;
  logic [7:0]         refund_amount_q, refund_amount_d;
  logic               coin_accepted_q, coin_accepted_d;
  logic               coin_rejected_q, coin_rejected_d;
  logic               refund_valid_q, refund_valid_d;
  logic               credit_err_q, credit_err_d;
  logic               g1_q, g2_q, ret_q;
  logic [2:0][CW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]         db_armed_q, db_armed_d;
  logic [2:0]         coin_raw_s;
  logic [2:0]         fire_s;
  logic [8:0]         weight_s;
  logic [8:0]         price_s;
  logic [8:0]         after_s;
  logic [8:0]         sum_s;
  logic               over_price_s;
  logic               ret_rise_s, ret_fall_s;

  assign coin_raw_s = {coin_5, coin_1, coin_p5};

  // While armed the counter runs on highs; once fired it runs on lows until re-armed.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_armed_d = db_armed_q;
    fire_s     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (db_armed_q[i]) begin
        if (coin_raw_s[i]) begin
          if (db_cnt_q[i] == CNT_LAST) begin
            fire_s[i]     = 1'b1;
            db_armed_d[i] = 1'b0;
            db_cnt_d[i]   = '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + CW'(1);
          end
        end else begin
          db_cnt_d[i] = '0;
        end
      end else begin
        if (!coin_raw_s[i]) begin
          if (db_cnt_q[i] == CNT_LAST) begin
            db_armed_d[i] = 1'b1;
            db_cnt_d[i]   = '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + CW'(1);
          end
        end else begin
          db_cnt_d[i] = '0;
        end
      end
    end
  end

  assign weight_s = (fire_s[0] ? 9'd1 : 9'd0) + (fire_s[1] ? 9'd2 : 9'd0) +
                    (fire_s[2] ? 9'd10 : 9'd0);
  assign price_s  = ((g1_bought && !g1_q) ? 9'(PRICE_G1) : 9'd0) +
                    ((g2_bought && !g2_q) ? 9'(PRICE_G2) : 9'd0);
  assign ret_rise_s = ret_coin && !ret_q;
  assign ret_fall_s = !ret_coin && ret_q;

  // Deduction first, then coins; all in 9 bits so the ceiling test sees the true sum.
  always_comb begin
    over_price_s = (price_s > {1'b0, credit_q});
    if (over_price_s) begin
      after_s = 9'd0;
    end else begin
      after_s = {1'b0, credit_q} - price_s;
    end
    sum_s = after_s + weight_s;
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    refund_amount_d = refund_amount_q;
    coin_accepted_d = 1'b0;
    coin_rejected_d = 1'b0;
    refund_valid_d  = 1'b0;
    credit_err_d    = credit_err_q;
    case (state_q)
      IDLE: begin
        credit_d        = 8'd0;
        credit_err_d    = 1'b0;
        coin_rejected_d = |fire_s;
        if (occupy) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (ret_rise_s || !occupy) begin
          state_d         = REFUND;
          refund_valid_d  = 1'b1;
          refund_amount_d = credit_q;
          credit_d        = 8'd0;
          coin_rejected_d = |fire_s;
        end else begin
          if (over_price_s) begin
            credit_err_d = 1'b1;
          end else begin
            credit_err_d = credit_err_q;
          end
          if (sum_s > 9'(MAX_CREDIT)) begin
            credit_d        = after_s[7:0];
            coin_rejected_d = |fire_s;
          end else begin
            credit_d        = sum_s[7:0];
            coin_accepted_d = |fire_s;
          end
        end
      end
      REFUND: begin
        credit_d        = 8'd0;
        coin_rejected_d = |fire_s;
        if (!occupy) begin
          state_d = IDLE;
        end else if (ret_fall_s) begin
          state_d = ACTIVE;
        end else begin
          state_d = REFUND;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      credit_q        <= 8'd0;
      refund_amount_q <= 8'd0;
      coin_accepted_q <= 1'b0;
      coin_rejected_q <= 1'b0;
      refund_valid_q  <= 1'b0;
      credit_err_q    <= 1'b0;
      g1_q            <= 1'b0;
      g2_q            <= 1'b0;
      ret_q           <= 1'b0;
      db_cnt_q        <= '0;
      db_armed_q      <= 3'b111;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      refund_amount_q <= refund_amount_d;
      coin_accepted_q <= coin_accepted_d;
      coin_rejected_q <= coin_rejected_d;
      refund_valid_q  <= refund_valid_d;
      credit_err_q    <= credit_err_d;
      g1_q            <= g1_bought;
      g2_q            <= g2_bought;
      ret_q           <= ret_coin;
      db_cnt_q        <= db_cnt_d;
      db_armed_q      <= db_armed_d;
    end
  end

  assign coin_value    = credit_q;
  assign coin_accepted = coin_accepted_q;
  assign coin_rejected = coin_rejected_q;
  assign refund_valid  = refund_valid_q;
  assign refund_amount = refund_amount_q;
  assign credit_err    = credit_err_q;
  assign state         = state_q;

endmodule

// File: tb/tb_vm_coin_acceptor.sv
// Directed bench for vm_coin_acceptor: a vector table for debounce/hold/purchase,
// then hand-written sequences for saturation, refund and boundary cases.
module tb_vm_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_p5 = 1'b0, coin_1 = 1'b0, coin_5 = 1'b0;
  logic       occupy = 1'b0, g1_bought = 1'b0, g2_bought = 1'b0, ret_coin = 1'b0;
  logic [7:0] coin_value, refund_amount;
  logic       coin_accepted, coin_rejected, refund_valid, credit_err;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int acc_n, rej_n, ref_n, ref_amt;

  typedef struct {
    logic occ, p5, c1, c5, g1, g2, ret;
    int   cyc;
    int   val, st, acc, rej, err;
  } vec_t;

  vec_t vecs[11];

  vm_coin_acceptor dut (
    .clk(clk), .rst(rst),
    .coin_p5(coin_p5), .coin_1(coin_1), .coin_5(coin_5),
    .occupy(occupy), .g1_bought(g1_bought), .g2_bought(g2_bought), .ret_coin(ret_coin),
    .coin_value(coin_value), .coin_accepted(coin_accepted), .coin_rejected(coin_rejected),
    .refund_valid(refund_valid), .refund_amount(refund_amount),
    .credit_err(credit_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    acc_n += int'(coin_accepted);
    rej_n += int'(coin_rejected);
    if (refund_valid) begin
      ref_n  += 1;
      ref_amt = int'(refund_amount);
    end
  endtask

  task automatic clr();
    acc_n = 0; rej_n = 0; ref_n = 0; ref_amt = -1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic coin(input int w);
    if (w == 1) coin_p5 = 1'b1;
    else if (w == 2) coin_1 = 1'b1;
    else coin_5 = 1'b1;
    repeat (4) tick();
    coin_p5 = 1'b0; coin_1 = 1'b0; coin_5 = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    //           occ   p5    c1    c5    g1    g2    ret   cyc val st acc rej err
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2,  0,  0, 0,  0,  0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3,  0,  0, 0,  0,  0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4,  0,  0, 0,  0,  0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0,  1, 0,  0,  0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4,  10, 1, 1,  0,  0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4,  10, 1, 0,  0,  0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 50, 12, 1, 1,  0,  0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20, 7,  1, 0,  0,  0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4,  7,  1, 0,  0,  0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4,  9,  1, 1,  0,  0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4,  9,  1, 0,  0,  0};

    clr();
    repeat (2) tick();
    rst = 1'b0;
    chk("reset coin_value", int'(coin_value), 0);
    chk("reset state", int'(state), 0);
    chk("reset accepted", int'(coin_accepted), 0);
    chk("reset rejected", int'(coin_rejected), 0);
    chk("reset refund_valid", int'(refund_valid), 0);
    chk("reset refund_amount", int'(refund_amount), 0);
    chk("reset credit_err", int'(credit_err), 0);

    for (int v = 0; v < 11; v++) begin
      occupy = vecs[v].occ; coin_p5 = vecs[v].p5; coin_1 = vecs[v].c1; coin_5 = vecs[v].c5;
      g1_bought = vecs[v].g1; g2_bought = vecs[v].g2; ret_coin = vecs[v].ret;
      clr();
      repeat (vecs[v].cyc) tick();
      chk($sformatf("vec%0d coin_value", v), int'(coin_value), vecs[v].val);
      chk($sformatf("vec%0d state", v), int'(state), vecs[v].st);
      chk($sformatf("vec%0d accepted pulses", v), acc_n, vecs[v].acc);
      chk($sformatf("vec%0d rejected pulses", v), rej_n, vecs[v].rej);
      chk($sformatf("vec%0d credit_err", v), int'(credit_err), vecs[v].err);
    end

    // Saturation: 9 + 18*10 + 3*2 = 195
    clr();
    for (int k = 0; k < 18; k++) coin(10);
    for (int k = 0; k < 3; k++) coin(2);
    chk("sat fill value", int'(coin_value), 195);
    chk("sat fill accepted", acc_n, 21);
    clr();
    coin(10);
    chk("sat reject pulse", rej_n, 1);
    chk("sat reject accepted", acc_n, 0);
    chk("sat reject value", int'(coin_value), 195);
    clr();
    coin(2);
    chk("sat small coin value", int'(coin_value), 197);
    chk("sat small coin accepted", acc_n, 1);

    // occupy drop refunds the full credit, then session ends
    clr();
    occupy = 1'b0;
    tick();
    chk("drop refund state", int'(state), 2);
    chk("drop refund value", int'(coin_value), 0);
    tick();
    chk("drop idle state", int'(state), 0);
    chk("drop refund count", ref_n, 1);
    chk("drop refund amount", ref_amt, 197);

    // Refund via ret_coin at credit 23
    occupy = 1'b1;
    tick();
    chk("session2 state", int'(state), 1);
    coin(10); coin(10); coin(2); coin(1);
    chk("session2 credit", int'(coin_value), 23);
    clr();
    ret_coin = 1'b1;
    tick();
    chk("ret refund_valid", int'(refund_valid), 1);
    chk("ret refund_amount", int'(refund_amount), 23);
    chk("ret coin_value", int'(coin_value), 0);
    chk("ret state", int'(state), 2);
    tick();
    chk("ret refund_valid one-shot", int'(refund_valid), 0);
    chk("ret refund_amount held", int'(refund_amount), 23);
    clr();
    coin(1);
    chk("refund coin rejected", rej_n, 1);
    chk("refund coin accepted", acc_n, 0);
    chk("refund state held", int'(state), 2);
    chk("refund credit held", int'(coin_value), 0);
    occupy = 1'b0;
    tick();
    chk("refund to idle", int'(state), 0);
    ret_coin = 1'b0;

    // Boundary: price above credit
    occupy = 1'b1;
    tick();
    coin(2); coin(2);
    chk("bnd credit 4", int'(coin_value), 4);
    g2_bought = 1'b1;
    tick();
    chk("bnd over-price value", int'(coin_value), 0);
    chk("bnd over-price err", int'(credit_err), 1);
    g2_bought = 1'b0;
    tick();
    coin(2); coin(2); coin(1);
    chk("bnd credit 5", int'(coin_value), 5);
    chk("bnd err sticky", int'(credit_err), 1);

    // Boundary: g1 edge lands in the same cycle as the coin_5 event
    clr();
    coin_5 = 1'b1;
    repeat (3) tick();
    g1_bought = 1'b1;
    tick();
    chk("bnd same-cycle value", int'(coin_value), 10);
    chk("bnd same-cycle accepted", int'(coin_accepted), 1);
    coin_5 = 1'b0;
    g1_bought = 1'b0;
    repeat (4) tick();
    chk("bnd same-cycle hold", int'(coin_value), 10);

    // Reset mid-session: everything clears, no refund pulse
    clr();
    rst = 1'b1;
    tick();
    chk("rst coin_value", int'(coin_value), 0);
    chk("rst state", int'(state), 0);
    chk("rst credit_err", int'(credit_err), 0);
    chk("rst refund_amount", int'(refund_amount), 0);
    chk("rst no refund pulse", ref_n, 0);
    chk("rst accepted", int'(coin_accepted), 0);
    rst = 1'b0;
    occupy = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
